inst_fetch_mem: RTL and testbench
=================================

INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of instruction words (power of two, 4..4096).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction word width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of the fetch and load ports.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port fetch_req, input, 1, fetch request.
REQ-007 SHALL have port fetch_addr, input, ADDR_WIDTH, byte address of the requested instruction.
REQ-008 SHALL have port fetch_ready, output, 1, block can accept a fetch this cycle.
REQ-009 SHALL have port inst_valid, output, 1, inst_out and fetch_fault are valid.
REQ-010 SHALL have port inst_out, output, DATA_WIDTH, the fetched instruction.
REQ-011 SHALL have port fetch_fault, output, 1, the fetch was misaligned or out of range.
REQ-012 SHALL have port inst_ack, input, 1, consumer accepts the current response.
REQ-013 SHALL have port load_we, input, 1, program-load write strobe.
REQ-014 SHALL have port load_addr, input, ADDR_WIDTH, byte address of the load write.
REQ-015 SHALL have port load_data, input, DATA_WIDTH, word to be written.
REQ-016 SHALL have port load_err, output, 1, one-cycle pulse on a rejected load write.

Function
REQ-017 SHALL implement FSM states CLEAR, IDLE and RESP; reset enters CLEAR.
REQ-018 In CLEAR, SHALL write zero to one word per cycle, index 0 to DEPTH-1, then go to IDLE; CLEAR therefore lasts exactly DEPTH cycles.
REQ-019 fetch_ready SHALL be 0 in CLEAR; 1 in IDLE; 1 in RESP only when inst_ack=1 that cycle.
REQ-020 A fetch is accepted when fetch_req=1 and fetch_ready=1; the response SHALL appear on the next edge with inst_valid=1 (1-cycle latency), and the FSM enters or stays in RESP.
REQ-021 In RESP, inst_out, fetch_fault and inst_valid SHALL hold stable until inst_ack=1; an ack with no new accepted fetch returns to IDLE with inst_valid=0; an ack with an accepted fetch gives back-to-back responses.
REQ-022 Word index = fetch_addr >> 2; fetch_addr[1:0]!=0 or index>=DEPTH SHALL give fetch_fault=1 and inst_out=0.
REQ-023 A load write is accepted in IDLE or RESP when load_we=1, load_addr[1:0]=0 and load_addr>>2 < DEPTH.
REQ-024 A load write is rejected with load_err=1 on the next cycle and memory unchanged in CLEAR, or when misaligned or out of range.
REQ-025 A fetch and load write to the same word in the same cycle SHALL return the old contents (read-before-write).
REQ-026 inst_ack while inst_valid=0 SHALL be ignored.

Reset
REQ-027 Asserting reset at any time, including mid-CLEAR or in RESP, SHALL immediately force inst_valid=0, inst_out=0, fetch_fault=0, fetch_ready=0, load_err=0 and state CLEAR with clear index 0.
REQ-028 After deassertion, CLEAR SHALL restart from index 0; no pending response survives reset.

Configuration
REQ-029 With macro INST_MEM_PARITY_EN defined, SHALL store one even-parity bit per word, computed on every load and clear write, and add output port parity_err (1 bit, reset 0), valid with inst_valid, set on read mismatch; fault responses SHALL give parity_err=0.
REQ-030 Without INST_MEM_PARITY_EN, SHALL have no parity storage and no parity_err port; all other behaviour is identical.

Verification
REQ-031 Reset release, DEPTH=64 -> fetch_ready stays 0 for exactly 64 cycles, then 1; fetch 0x0 -> inst_out=0x00000000, fetch_fault=0.
REQ-032 Load 0x8C080000 @0x0 and 0x8C090020 @0x4; fetch 0x4, ack held 1 -> inst_out=0x8C090020 one cycle later; fetch 0x0 next cycle -> 0x8C080000 back-to-back.
REQ-033 Fetch 0x2 -> fetch_fault=1, inst_out=0; fetch 0x100 (index 64) -> fetch_fault=1; load to 0x100 -> load_err pulse, memory unchanged.
REQ-034 Fetch 0x8, inst_ack=0 for 3 cycles -> inst_valid and inst_out stable, fetch_ready=0; ack -> return to IDLE.
REQ-035 Same-cycle load 0x1234 and fetch @0xC holding 0xAAAA -> inst_out=0xAAAA; refetch -> 0x1234; reset asserted in RESP -> inst_valid=0 at once, CLEAR restarts.
REQ-036 With INST_MEM_PARITY_EN, force a parity-bit flip at word 3 and fetch 0xC -> parity_err=1 with inst_valid=1.

Source files
------------

// File: rtl/inst_fetch_mem.sv
// Instruction memory with fetch/response handshake, program-load port and power-up clear sweep.
// Define INST_MEM_PARITY_EN to add per-word even parity and the parity_err output.
//
// state | meaning
// CLEAR | zeroing one word per cycle, index 0..DEPTH-1; no fetches or loads accepted
// IDLE  | no response pending; fetches and loads accepted
// RESP  | response held on inst_out until inst_ack
module inst_fetch_mem #(
   parameter int DEPTH      = 64,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic                  fetch_ready,
   output logic                  inst_valid,
   output logic [DATA_WIDTH-1:0] inst_out,
   output logic                  fetch_fault,
   input  logic                  inst_ack,
   input  logic                  load_we,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_err
`ifdef INST_MEM_PARITY_EN
   ,
   output logic                  parity_err
`endif
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IDX_W-1:0]      r_clr_idx;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_inst;
   logic                  r_fault;
   logic                  r_load_err;

   logic [ADDR_WIDTH-1:0] w_fword;
   logic [ADDR_WIDTH-1:0] w_lword;
   logic                  w_fetch_fault;
   logic                  w_load_ok;
   logic                  w_accept;
   logic                  w_ready;
   logic                  w_clr_last;
   logic [DATA_WIDTH-1:0] w_rd_word;

   assign w_fword       = fetch_addr >> 2;
   assign w_lword       = load_addr >> 2;
   assign w_fetch_fault = (fetch_addr[1:0] != 2'b00) || (w_fword >= ADDR_WIDTH'(DEPTH));
   assign w_load_ok     = load_we && (r_state != CLEAR) && (load_addr[1:0] == 2'b00)
                          && (w_lword < ADDR_WIDTH'(DEPTH));
   assign w_ready       = (r_state == IDLE) || ((r_state == RESP) && inst_ack);
   assign w_accept      = fetch_req && w_ready;
   assign w_clr_last    = (r_clr_idx == IDX_W'(DEPTH - 1));
   assign w_rd_word     = r_mem[w_fword[IDX_W-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= CLEAR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         CLEAR: if (w_clr_last) w_state_nxt = IDLE;
         IDLE:  if (w_accept)   w_state_nxt = RESP;
         RESP:  if (inst_ack)   w_state_nxt = w_accept ? RESP : IDLE;
         default:               w_state_nxt = CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_clr_idx  <= '0;
         r_valid    <= 1'b0;
         r_inst     <= '0;
         r_fault    <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_load_err <= load_we && !w_load_ok;
         if (r_state == CLEAR) r_clr_idx <= r_clr_idx + IDX_W'(1);
         if (w_accept) begin
            r_valid <= 1'b1;
            r_fault <= w_fetch_fault;
            r_inst  <= w_fetch_fault ? '0 : w_rd_word;
         end else if ((r_state == RESP) && inst_ack) begin
            r_valid <= 1'b0;
         end
      end
   end

   // Memory has no reset; the CLEAR sweep zeroes it. Nonblocking write gives read-before-write.
   always_ff @(posedge clk) begin
      if (r_state == CLEAR) begin
         r_mem[r_clr_idx] <= '0;
      end else if (w_load_ok) begin
         r_mem[w_lword[IDX_W-1:0]] <= load_data;
      end
   end

`ifdef INST_MEM_PARITY_EN
   logic r_par [DEPTH];
   logic r_par_err;

   always_ff @(posedge clk) begin
      if (r_state == CLEAR) begin
         r_par[r_clr_idx] <= 1'b0;
      end else if (w_load_ok) begin
         r_par[w_lword[IDX_W-1:0]] <= ^load_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_par_err <= 1'b0;
      end else if (w_accept) begin
         r_par_err <= !w_fetch_fault && ((^w_rd_word) != r_par[w_fword[IDX_W-1:0]]);
      end else if ((r_state == RESP) && inst_ack) begin
         r_par_err <= 1'b0;
      end
   end

   assign parity_err = r_par_err;
`endif

   assign fetch_ready = w_ready;
   assign inst_valid  = r_valid;
   assign inst_out    = r_inst;
   assign fetch_fault = r_fault;
   assign load_err    = r_load_err;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Directed bench for inst_fetch_mem (DEPTH=64): clear sweep, fetch/ack handshake, faults, loads, reset.
// Parity check is compiled only when INST_MEM_PARITY_EN is defined.
module tb_inst_fetch_mem;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_ready;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic        fetch_fault;
   logic        inst_ack;
   logic        load_we;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   logic        load_err;
`ifdef INST_MEM_PARITY_EN
   logic        parity_err;
`endif

   int total = 0;
   int bad   = 0;

   inst_fetch_mem #(.DEPTH(64), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_ready (fetch_ready),
      .inst_valid  (inst_valid),
      .inst_out    (inst_out),
      .fetch_fault (fetch_fault),
      .inst_ack    (inst_ack),
      .load_we     (load_we),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .load_err    (load_err)
`ifdef INST_MEM_PARITY_EN
      ,
      .parity_err  (parity_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      load_we = 1'b1; load_addr = a; load_data = d;
      tick();
      load_we = 1'b0;
   endtask

   // Counts cycles until fetch_ready rises; cnt0 covers cycles already spent in CLEAR.
   task automatic wait_clear(input string tag, input int cnt0);
      int cnt = cnt0;
      while (!fetch_ready && cnt < 200) begin
         tick();
         cnt++;
      end
      chk(tag, cnt, 64);
   endtask

   initial begin
      reset = 1'b0; fetch_req = 1'b0; fetch_addr = '0; inst_ack = 1'b0;
      load_we = 1'b0; load_addr = '0; load_data = '0;
      tick(); tick(); tick();
      chk("rst_ready", fetch_ready, 0);
      chk("rst_valid", inst_valid, 0);
      chk("rst_inst", inst_out, 0);
      chk("rst_fault", fetch_fault, 0);
      chk("rst_lerr", load_err, 0);
      reset = 1'b1;
      wait_clear("clear_len", 0);

      fetch_req = 1'b1; fetch_addr = 32'h0;
      tick();
      fetch_req = 1'b0;
      chk("f0_valid", inst_valid, 1);
      chk("f0_inst", inst_out, 32'h0);
      chk("f0_fault", fetch_fault, 0);
      inst_ack = 1'b1; tick(); inst_ack = 1'b0;
      chk("f0_ackidle", inst_valid, 0);

      load(32'h0, 32'h8C080000);
      load(32'h4, 32'h8C090020);
      load(32'h8, 32'h55AA55AA);
      chk("load_ok_noerr", load_err, 0);

      fetch_req = 1'b1; fetch_addr = 32'h4; inst_ack = 1'b1;
      tick();
      chk("b2b_a_valid", inst_valid, 1);
      chk("b2b_a_inst", inst_out, 32'h8C090020);
      chk("b2b_ready", fetch_ready, 1);
      fetch_addr = 32'h0;
      tick();
      chk("b2b_b_valid", inst_valid, 1);
      chk("b2b_b_inst", inst_out, 32'h8C080000);
      fetch_req = 1'b0;
      tick();
      inst_ack = 1'b0;
      chk("b2b_idle", inst_valid, 0);

      fetch_req = 1'b1; fetch_addr = 32'h2;
      tick();
      chk("mis_fault", fetch_fault, 1);
      chk("mis_inst", inst_out, 0);
      inst_ack = 1'b1; fetch_addr = 32'h100;
      tick();
      chk("oor_valid", inst_valid, 1);
      chk("oor_fault", fetch_fault, 1);
      chk("oor_inst", inst_out, 0);
      fetch_req = 1'b0;
      tick();
      inst_ack = 1'b0;

      load(32'h100, 32'hDEADBEEF);
      chk("lerr_oor", load_err, 1);
      tick();
      chk("lerr_pulse", load_err, 0);
      load(32'h1, 32'hFFFFFFFF);
      chk("lerr_mis", load_err, 1);
      fetch_req = 1'b1; fetch_addr = 32'h0;
      tick();
      fetch_req = 1'b0;
      chk("lerr_memkeep", inst_out, 32'h8C080000);
      chk("lerr_fault", fetch_fault, 0);
      inst_ack = 1'b1; tick(); inst_ack = 1'b0;

      fetch_req = 1'b1; fetch_addr = 32'h8;
      tick();
      fetch_addr = 32'h4;
      for (int i = 0; i < 3; i++) begin
         chk("stall_ready", fetch_ready, 0);
         tick();
         chk("stall_valid", inst_valid, 1);
         chk("stall_inst", inst_out, 32'h55AA55AA);
      end
      fetch_req = 1'b0; inst_ack = 1'b1;
      tick();
      inst_ack = 1'b0;
      chk("stall_idle_valid", inst_valid, 0);
      chk("stall_idle_ready", fetch_ready, 1);

      load(32'hC, 32'h0000AAAA);
      load_we = 1'b1; load_addr = 32'hC; load_data = 32'h00001234;
      fetch_req = 1'b1; fetch_addr = 32'hC;
      tick();
      load_we = 1'b0;
      chk("rbw_old", inst_out, 32'h0000AAAA);
      inst_ack = 1'b1;
      tick();
      inst_ack = 1'b0; fetch_req = 1'b0;
      chk("rbw_new", inst_out, 32'h00001234);
      chk("rbw_valid", inst_valid, 1);

      reset = 1'b0;
      #1;
      chk("rrst_valid", inst_valid, 0);
      chk("rrst_inst", inst_out, 0);
      chk("rrst_ready", fetch_ready, 0);
      reset = 1'b1;
      load_we = 1'b1; load_addr = 32'h0; load_data = 32'hDEADBEEF;
      tick();
      load_we = 1'b0;
      chk("clr_lerr", load_err, 1);
      chk("clr_valid", inst_valid, 0);
      wait_clear("reclear_len", 1);
      fetch_req = 1'b1; fetch_addr = 32'hC;
      tick();
      fetch_req = 1'b0;
      chk("reclear_inst", inst_out, 0);
      inst_ack = 1'b1; tick(); inst_ack = 1'b0;

`ifdef INST_MEM_PARITY_EN
      load(32'hC, 32'h00000007);
      dut.r_par[3] = ~dut.r_par[3];
      fetch_req = 1'b1; fetch_addr = 32'hC;
      tick();
      fetch_req = 1'b0;
      chk("par_valid", inst_valid, 1);
      chk("par_err", parity_err, 1);
      inst_ack = 1'b1; tick(); inst_ack = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
